// File: rtl/sci2_tx_scheduler.sv
// Round-robin SCI2 command scheduler/serializer: accepts one command per grant, shifts 13-bit frames LSB-first per bit_en.
// Latency: first bit on the first bit_en after grant; backpressure: req_ready pulses only in IDLE, never while a command or gap is in flight.
module sci2_tx_scheduler #(
    parameter int GAP_BITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_en,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [17:0] req_cmd,
    input  logic [5:0]  req_len,
    input  logic [71:0] req_info,
    output logic        data_a,
    output logic        data_b,
    output logic        busy,
    output logic        grant_id,
    output logic        done,
    output logic        err_len
);
    localparam int MAX_WORDS = 5;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t          state, state_nx;
    logic            last_gnt;
    logic [8:0]      cmd_q;
    logic [2:0]      len_q;
    logic [3:0][8:0] info_q;
    logic [2:0]      widx;
    logic [3:0]      bidx;
    logic [7:0]      gap_cnt;

    logic            gnt_any;
    logic            gnt;
    logic [2:0]      sel_len;
    logic            len_ok;
    logic            last_bit;
    logic            gap_end;
    logic [8:0]      wdata;
    logic            mark;
    logic [12:0]     word;

    // The requester not granted last wins a tie.
    always_comb begin
        gnt_any = |req_valid;
        gnt     = (req_valid == 2'b11) ? ~last_gnt : req_valid[1];
        sel_len = gnt ? req_len[5:3] : req_len[2:0];
        len_ok  = (sel_len != 3'd0) && (sel_len <= 3'(MAX_WORDS));
    end

    always_comb begin
        last_bit = (widx == len_q - 3'd1) && (bidx == 4'd12);
        gap_end  = (gap_cnt == 8'(GAP_BITS - 1));
        mark     = (widx == 3'd0);
        wdata    = mark ? cmd_q : info_q[widx[1:0] - 2'd1];
        word     = {1'b1, ~^{mark, wdata}, mark, wdata, 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (gnt_any && len_ok)   state_nx = SHIFT;
            SHIFT:   if (bit_en && last_bit)  state_nx = GAP;
            GAP:     if (bit_en && gap_end)   state_nx = IDLE;
            default:                          state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && gnt_any) req_ready = gnt ? 2'b10 : 2'b01;
        busy   = (state != IDLE);
        data_b = ~data_a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_a   <= 1'b1;
            done     <= 1'b0;
            err_len  <= 1'b0;
            grant_id <= 1'b0;
            last_gnt <= 1'b1;
            cmd_q    <= '0;
            len_q    <= '0;
            info_q   <= '0;
            widx     <= '0;
            bidx     <= '0;
            gap_cnt  <= '0;
        end else begin
            done    <= 1'b0;
            err_len <= 1'b0;
            case (state)
                IDLE: begin
                    data_a <= 1'b1;
                    if (gnt_any) begin
                        grant_id <= gnt;
                        last_gnt <= gnt;
                        cmd_q    <= gnt ? req_cmd[17:9]   : req_cmd[8:0];
                        info_q   <= gnt ? req_info[71:36] : req_info[35:0];
                        len_q    <= sel_len;
                        err_len  <= ~len_ok;
                        widx     <= '0;
                        bidx     <= '0;
                        gap_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (bit_en) begin
                        data_a <= word[bidx];
                        if (last_bit) begin
                            done <= 1'b1;
                        end else if (bidx == 4'd12) begin
                            bidx <= '0;
                            widx <= widx + 3'd1;
                        end else begin
                            bidx <= bidx + 4'd1;
                        end
                    end
                end
                GAP: begin
                    if (bit_en) begin
                        data_a  <= 1'b1;
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: data_a <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_sci2_tx_scheduler.sv
// Scoreboard bench for sci2_tx_scheduler: stimulus queues expected grants and line bits, a negedge monitor consumes them.
module tb_sci2_tx_scheduler;
    localparam int GAP = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_en = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [17:0] req_cmd = '0;
    logic [5:0]  req_len = '0;
    logic [71:0] req_info = '0;
    logic        data_a, data_b, busy, grant_id, done, err_len;

    sci2_tx_scheduler #(.GAP_BITS(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_len(req_len), .req_info(req_info),
        .data_a(data_a), .data_b(data_b), .busy(busy),
        .grant_id(grant_id), .done(done), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    bit exp_bits[$];
    int exp_lens[$];
    int exp_gnt[$];
    bit exp_legal[$];

    // Bit strobe every second clock unless frozen.
    bit freeze = 1'b0;
    int en_cnt = 0;
    initial forever begin
        @(posedge clk);
        #1;
        en_cnt++;
        bit_en = !freeze && (en_cnt % 2 == 0);
    end

    bit en_q = 1'b0, busy_q = 1'b0;
    always @(posedge clk) begin
        en_q   = bit_en;
        busy_q = busy;
    end

    bit in_frame = 0, in_gap = 0, busy_prev = 0, err_exp = 0, chk_gid = 0, leg, eb, fdone;
    int gid_exp = 0, bitcnt = 0, gapcnt = 0, grants = 0, g;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 0; in_gap = 0; busy_prev = 0; err_exp = 0; chk_gid = 0;
        end else begin
            fdone = 0;
            if (chk_gid) begin
                check("grant_id", grant_id, gid_exp);
                check("err_len", err_len, err_exp);
                chk_gid = 0;
            end else if (err_len) begin
                check("err_len_stray", err_len, 0);
            end
            if (req_ready != 2'b00) begin
                if (exp_gnt.size() == 0) begin
                    check("grant_unexpected", req_ready, 0);
                end else begin
                    g   = exp_gnt.pop_front();
                    leg = exp_legal.pop_front();
                    check("req_ready", req_ready, 1 << g);
                    gid_exp = g; err_exp = !leg; chk_gid = 1; grants++;
                end
            end
            if (busy && !busy_prev) begin
                in_frame = 1; bitcnt = 0;
            end
            if (in_frame && en_q && busy_q) begin
                if (exp_bits.size() == 0) begin
                    check("bit_underflow", 1, 0);
                end else begin
                    eb = exp_bits.pop_front();
                    check("data_a_bit", data_a, eb);
                    check("data_b_bit", data_b, !eb);
                end
                bitcnt++;
                if (done) begin
                    fdone = 1; in_frame = 0; in_gap = 1; gapcnt = 0;
                    check("frame_bits", bitcnt, (exp_lens.size() != 0) ? exp_lens.pop_front() : -1);
                end
            end else if (in_gap && en_q && busy_q) begin
                check("gap_level", {data_a, data_b}, 2'b10);
                gapcnt++;
            end
            if (done && !fdone) check("done_stray", done, 0);
            if (in_gap && !busy) begin
                check("gap_bits", gapcnt, GAP);
                in_gap = 0;
            end
            if (in_frame && !busy) begin
                check("frame_abort", 0, 1);
                in_frame = 0;
            end
            busy_prev = busy;
        end
    end

    task automatic push_word(input logic [8:0] d, input bit mark);
        int ones;
        ones = mark;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 9; i++) begin
            exp_bits.push_back(d[i]);
            ones += d[i];
        end
        exp_bits.push_back(mark);
        exp_bits.push_back(ones % 2 == 0);
        exp_bits.push_back(1'b1);
    endtask

    task automatic push_cmd(input int gi, input logic [8:0] cmd, input int len, input logic [35:0] info);
        exp_gnt.push_back(gi);
        exp_legal.push_back(len >= 1 && len <= 5);
        if (len >= 1 && len <= 5) begin
            push_word(cmd, 1'b1);
            for (int k = 0; k < len - 1; k++) push_word(info[9*k +: 9], 1'b0);
            exp_lens.push_back(len * 13);
        end
    endtask

    task automatic set_req(input int gi, input logic [8:0] cmd, input logic [2:0] len, input logic [35:0] info);
        req_cmd[9*gi +: 9]   = cmd;
        req_len[3*gi +: 3]   = len;
        req_info[36*gi +: 36] = info;
    endtask

    // Present one request for a single grant edge, then scramble its fields.
    task automatic issue(input int gi);
        @(posedge clk); #1;
        req_valid[gi] = 1'b1;
        @(posedge clk); #1;
        req_valid[gi] = 1'b0;
        set_req(gi, 9'($urandom), 3'($urandom), 36'($urandom));
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_gnt.size() == 0 && exp_lens.size() == 0 && !busy && !in_gap && !in_frame) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    task automatic wait_bits(input string name, input int n, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (in_frame && bitcnt >= n) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        string w;
        logic [7:0] snap;
        int snapcnt;
        bit ok;

        repeat (3) @(posedge clk);
        #1;
        check("rst_lines", {data_a, data_b}, 2'b10);
        check("rst_ready", req_ready, 0);
        check("rst_flags", {busy, grant_id, done, err_len}, 4'b0000);
        rst_n = 1'b1;

        // Both requesters held from reset: grants alternate 0,1,0,1.
        set_req(0, 9'h0C3, 3'd1, 36'h0);
        set_req(1, 9'h12D, 3'd1, 36'h0);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push_cmd(0, 9'h0C3, 1, 36'h0);
            else            push_cmd(1, 9'h12D, 1, 36'h0);
        end
        @(posedge clk); #1;
        req_valid = 2'b11;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (grants >= 4) begin ok = 1; break; end
        end
        check("alt_grants", ok, 1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_idle("alt_drain", 2000);

        // Hand-framed two-word command from requester 0.
        set_req(0, 9'h041, 3'd2, {27'h0, 9'h084});
        exp_gnt.push_back(0);
        exp_legal.push_back(1'b1);
        w = {"0100000100101", "0001000010011"};
        for (int i = 0; i < w.len(); i++) exp_bits.push_back(w[i] == "1");
        exp_lens.push_back(26);
        issue(0);
        wait_idle("single_drain", 1000);

        // Illegal length: accepted, flagged, line stays idle.
        set_req(1, 9'h0FF, 3'd0, 36'h0);
        push_cmd(1, 9'h0FF, 0, 36'h0);
        issue(1);
        repeat (3) @(negedge clk);
        check("len0_idle", {busy, data_a, data_b}, 3'b010);
        wait_idle("len0_drain", 50);

        // Maximum length with parity corner words.
        set_req(0, 9'h0A5, 3'd5, {9'h0AA, 9'h155, 9'h000, 9'h1FF});
        push_cmd(0, 9'h0A5, 5, {9'h0AA, 9'h155, 9'h000, 9'h1FF});
        issue(0);
        wait_idle("len5_drain", 2000);

        // Strobe frozen mid-frame.
        set_req(1, 9'h133, 3'd3, {18'h0, 9'h0F0, 9'h00F});
        push_cmd(1, 9'h133, 3, {18'h0, 9'h0F0, 9'h00F});
        issue(1);
        wait_bits("freeze_reach", 15, 500);
        freeze = 1'b1;
        repeat (3) @(negedge clk);
        snap = {7'h0, data_a};
        snapcnt = bitcnt;
        repeat (50) @(negedge clk);
        check("freeze_data", {7'h0, data_a}, snap);
        check("freeze_bits", bitcnt, snapcnt);
        freeze = 1'b0;
        wait_idle("freeze_drain", 1000);

        // Reset at bit 20 of a three-word command, then a clean command.
        set_req(0, 9'h0E7, 3'd3, {18'h0, 9'h001, 9'h100});
        push_cmd(0, 9'h0E7, 3, {18'h0, 9'h001, 9'h100});
        issue(0);
        wait_bits("reset_reach", 20, 500);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_lines", {data_a, data_b}, 2'b10);
        check("abort_flags", {busy, done, grant_id}, 3'b000);
        exp_bits.delete();
        exp_lens.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_req(1, 9'h02A, 3'd1, 36'h0);
        push_cmd(1, 9'h02A, 1, 36'h0);
        issue(1);
        wait_idle("post_reset_drain", 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
